// File: rtl/cpu_control_unit.sv
// rtl/cpu_control_unit.sv - multi-cycle control sequencer driving the datapath control word
module cpu_control_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] INSTRUCTION,
    input  logic        ZERO,
    input  logic        MEM_RDY,
    output logic [31:0] CTRL,
    output logic        READ,
    output logic        WRITE,
    output logic [2:0]  STATE
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_EXECUTE   = 3'd3;
    localparam logic [2:0] S_MEMORY    = 3'd4;
    localparam logic [2:0] S_WRITEBACK = 3'd5;

    localparam logic [3:0] ALU_NONE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_MUL  = 4'd3;
    localparam logic [3:0] ALU_SHR  = 4'd4;
    localparam logic [3:0] ALU_SHL  = 4'd5;
    localparam logic [3:0] ALU_AND  = 4'd6;
    localparam logic [3:0] ALU_OR   = 4'd7;
    localparam logic [3:0] ALU_NOR  = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;

    localparam int B_PC_LOAD  = 0;
    localparam int B_PC_SEL1  = 1;
    localparam int B_PC_SEL2  = 2;
    localparam int B_PC_SEL3  = 3;
    localparam int B_IR_LOAD  = 4;
    localparam int B_MEM_R    = 5;
    localparam int B_MEM_W    = 6;
    localparam int B_R1_SEL1  = 7;
    localparam int B_REG_R    = 8;
    localparam int B_REG_W    = 9;
    localparam int B_WA_SEL1  = 10;
    localparam int B_WA_SEL2  = 11;
    localparam int B_WA_SEL3  = 12;
    localparam int B_WD_SEL1  = 13;
    localparam int B_WD_SEL2  = 14;
    localparam int B_WD_SEL3  = 15;
    localparam int B_SP_LOAD  = 16;
    localparam int B_OP1_SEL1 = 17;
    localparam int B_OP2_SEL1 = 18;
    localparam int B_OP2_SEL2 = 19;
    localparam int B_OP2_SEL3 = 20;
    localparam int B_OP2_SEL4 = 21;
    localparam int B_MA_SEL1  = 26;
    localparam int B_MA_SEL2  = 27;
    localparam int B_MD_SEL1  = 28;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic        r_zero_q;
    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic [3:0]  w_alu;
    logic        w_r_alu, w_shift, w_jr, w_i_alu, w_i_zext, w_lui;
    logic        w_beq, w_bne, w_lw, w_sw, w_jmp, w_jal, w_push, w_pop;
    logic        w_mem_op;
    logic        w_branch_taken;
    logic [31:0] w_ctrl;
    logic        w_unused_instr;

    assign w_opcode       = INSTRUCTION[31:26];
    assign w_funct        = INSTRUCTION[5:0];
    assign w_unused_instr = ^INSTRUCTION[25:6];

    always_comb begin
        w_r_alu  = 1'b0;
        w_shift  = 1'b0;
        w_jr     = 1'b0;
        w_i_alu  = 1'b0;
        w_i_zext = 1'b0;
        w_lui    = 1'b0;
        w_beq    = 1'b0;
        w_bne    = 1'b0;
        w_lw     = 1'b0;
        w_sw     = 1'b0;
        w_jmp    = 1'b0;
        w_jal    = 1'b0;
        w_push   = 1'b0;
        w_pop    = 1'b0;
        w_alu    = ALU_NONE;
        if (w_opcode == 6'h00) begin
            case (w_funct)
                6'h20: begin w_r_alu = 1'b1; w_alu = ALU_ADD; end
                6'h22: begin w_r_alu = 1'b1; w_alu = ALU_SUB; end
                6'h2C: begin w_r_alu = 1'b1; w_alu = ALU_MUL; end
                6'h24: begin w_r_alu = 1'b1; w_alu = ALU_AND; end
                6'h25: begin w_r_alu = 1'b1; w_alu = ALU_OR;  end
                6'h27: begin w_r_alu = 1'b1; w_alu = ALU_NOR; end
                6'h2A: begin w_r_alu = 1'b1; w_alu = ALU_SLT; end
                6'h01: begin w_shift = 1'b1; w_alu = ALU_SHL; end
                6'h02: begin w_shift = 1'b1; w_alu = ALU_SHR; end
                6'h08: w_jr = 1'b1;
                default: ;
            endcase
        end else begin
            case (w_opcode)
                6'h08: begin w_i_alu = 1'b1; w_alu = ALU_ADD; end
                6'h1D: begin w_i_alu = 1'b1; w_alu = ALU_MUL; end
                6'h0C: begin w_i_alu = 1'b1; w_alu = ALU_AND; w_i_zext = 1'b1; end
                6'h0D: begin w_i_alu = 1'b1; w_alu = ALU_OR;  w_i_zext = 1'b1; end
                6'h0A: begin w_i_alu = 1'b1; w_alu = ALU_SLT; end
                6'h0F: w_lui = 1'b1;
                6'h04: begin w_beq = 1'b1; w_alu = ALU_SUB; end
                6'h05: begin w_bne = 1'b1; w_alu = ALU_SUB; end
                6'h23: begin w_lw  = 1'b1; w_alu = ALU_ADD; end
                6'h2B: begin w_sw  = 1'b1; w_alu = ALU_ADD; end
                6'h02: w_jmp  = 1'b1;
                6'h03: w_jal  = 1'b1;
                6'h1B: w_push = 1'b1;
                6'h1C: begin w_pop = 1'b1; w_alu = ALU_ADD; end
                default: ;
            endcase
        end
    end

    assign w_mem_op       = w_lw | w_sw | w_push | w_pop;
    assign w_branch_taken = (w_beq & r_zero_q) | (w_bne & ~r_zero_q);

    always_comb begin
        w_next_state = S_IDLE;
        case (r_state)
            S_IDLE:      w_next_state = S_FETCH;
            S_FETCH:     w_next_state = MEM_RDY ? S_DECODE : S_FETCH;
            S_DECODE:    w_next_state = S_EXECUTE;
            S_EXECUTE:   w_next_state = S_MEMORY;
            S_MEMORY:    w_next_state = (w_mem_op && !MEM_RDY) ? S_MEMORY : S_WRITEBACK;
            S_WRITEBACK: w_next_state = S_FETCH;
            default:     w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_zero_q <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_EXECUTE)
                r_zero_q <= ZERO;
        end
    end

    always_comb begin
        w_ctrl = 32'd0;
        case (r_state)
            S_FETCH: begin
                w_ctrl[B_MA_SEL2] = 1'b1;
                w_ctrl[B_MEM_R]   = 1'b1;
                w_ctrl[B_IR_LOAD] = 1'b1;
            end
            S_DECODE: begin
                w_ctrl[B_REG_R]   = 1'b1;
                w_ctrl[B_R1_SEL1] = w_push | w_pop;
            end
            S_EXECUTE: begin
                w_ctrl[B_REG_R]     = 1'b1;
                w_ctrl[25:22]       = w_alu;
                w_ctrl[B_OP2_SEL4]  = w_r_alu | w_beq | w_bne;
                w_ctrl[B_OP2_SEL2]  = (w_i_alu & ~w_i_zext) | w_lw | w_sw;
                w_ctrl[B_OP2_SEL1]  = w_shift;
                w_ctrl[B_OP2_SEL3]  = w_shift | w_pop;
                w_ctrl[B_OP1_SEL1]  = w_pop;
                w_ctrl[B_SP_LOAD]   = w_pop;
            end
            S_MEMORY: begin
                w_ctrl[B_MA_SEL1] = w_push | w_pop;
                w_ctrl[B_MEM_R]   = w_lw | w_pop;
                w_ctrl[B_MEM_W]   = w_sw | w_push;
                w_ctrl[B_MD_SEL1] = w_push;
                w_ctrl[B_R1_SEL1] = w_push;
                // load data is written back only in the cycle memory completes
                if ((w_lw || w_pop) && MEM_RDY) begin
                    w_ctrl[B_WD_SEL1] = 1'b1;
                    w_ctrl[B_WD_SEL3] = 1'b1;
                    w_ctrl[B_REG_W]   = 1'b1;
                    w_ctrl[B_WA_SEL3] = w_lw;
                    w_ctrl[B_WA_SEL1] = w_lw;
                end
            end
            S_WRITEBACK: begin
                w_ctrl[B_PC_LOAD] = 1'b1;
                w_ctrl[B_REG_R]   = 1'b1;
                w_ctrl[B_PC_SEL1] = ~(w_jmp | w_jal | w_jr | w_branch_taken);
                w_ctrl[B_PC_SEL2] = w_branch_taken;
                w_ctrl[B_PC_SEL3] = ~(w_jmp | w_jal);
                if (w_r_alu || w_shift || w_i_alu || w_lui) begin
                    w_ctrl[B_REG_W]   = 1'b1;
                    w_ctrl[B_WD_SEL3] = 1'b1;
                    w_ctrl[B_WA_SEL3] = 1'b1;
                    w_ctrl[B_WA_SEL1] = w_i_alu | w_lui;
                    w_ctrl[B_WD_SEL2] = w_lui;
                end
                if (w_jal) begin
                    w_ctrl[B_REG_W]   = 1'b1;
                    w_ctrl[B_WA_SEL2] = 1'b1;
                end
                if (w_push) begin
                    w_ctrl[B_OP1_SEL1] = 1'b1;
                    w_ctrl[B_OP2_SEL3] = 1'b1;
                    w_ctrl[B_SP_LOAD]  = 1'b1;
                    w_ctrl[25:22]      = ALU_SUB;
                end
            end
            default: w_ctrl = 32'd0;
        endcase
    end

    assign CTRL  = w_ctrl;
    assign READ  = w_ctrl[B_MEM_R];
    assign WRITE = w_ctrl[B_MEM_W];
    assign STATE = r_state;

endmodule
